// File: rtl/wb_trace_pkg.sv
// Shared record layout for the write-back trace buffer.
package wb_trace_pkg;
  localparam int TRACE_REC_W = 73;
  localparam int PC_LSB      = 41;
  localparam int WEN_LSB     = 37;
  localparam int WNUM_LSB    = 32;
  localparam int WDATA_LSB   = 0;

  // Field order matches the offsets above: pc[72:41] wen[40:37] wnum[36:32] wdata[31:0].
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_rec_t;
endpackage

// File: rtl/trace_fifo_mem.sv
// Trace record storage: one synchronous write port, one asynchronous read port, no reset.
module trace_fifo_mem
  import wb_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  trace_rec_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output trace_rec_t        rdata
);
  trace_rec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/wb_trace_buffer.sv
// Captures CPU write-back records into a FIFO and drains them over valid/ready.
// Define WB_TRACE_R0_FILTER_EN to ignore writes to register $0.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic [31:0]              wb_pc,
  input  logic [3:0]               wb_rf_wen,
  input  logic [4:0]               wb_rf_wnum,
  input  logic [31:0]              wb_rf_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [3:0]               out_wen,
  output logic [4:0]               out_wnum,
  output logic [31:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic              cap, push, pop, drop;
  trace_rec_t        wr_rec, head;

`ifdef WB_TRACE_R0_FILTER_EN
  assign cap = trace_en && (wb_rf_wen != 4'b0000) && (wb_rf_wnum != 5'd0);
`else
  assign cap = trace_en && (wb_rf_wen != 4'b0000);
`endif

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A pop on a full FIFO frees the slot in the same cycle.
  assign push      = cap && ((level < LVL_W'(DEPTH)) || pop);
  assign drop      = cap && !push;

  assign wr_rec = '{pc: wb_pc, wen: wb_rf_wen, wnum: wb_rf_wnum, wdata: wb_rf_wdata};

  trace_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Head fields read as zero when empty so reset presents a clean record.
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_wen   = out_valid ? head.wen   : '0;
  assign out_wnum  = out_valid ? head.wnum  : '0;
  assign out_wdata = out_valid ? head.wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)              drop_cnt <= CNT_W'(1);
      else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomized and directed bench for wb_trace_buffer against a queue-based model.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0, reset = 1'b1;
  logic              trace_en = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [31:0]       wb_pc = '0, wb_rf_wdata = '0;
  logic [3:0]        wb_rf_wen = '0;
  logic [4:0]        wb_rf_wnum = '0;
  logic              out_valid, overflow;
  logic [31:0]       out_pc, out_wdata;
  logic [3:0]        out_wen;
  logic [4:0]        out_wnum;
  logic [4:0]        level;
  logic [CNT_W-1:0]  drop_cnt;

  int n_cmp = 0, n_fail = 0;

  wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen), .wb_rf_wnum(wb_rf_wnum), .wb_rf_wdata(wb_rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [72:0] act, input logic [72:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records plus drop bookkeeping.
  trace_rec_t q[$];
  bit         m_ovf;
  int         m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      bit c, d;
      c = trace_en && (wb_rf_wen != 0);
`ifdef WB_TRACE_R0_FILTER_EN
      c = c && (wb_rf_wnum != 0);
`endif
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      d = 0;
      if (c) begin
        if (q.size() < DEPTH) q.push_back('{wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata});
        else d = 1;
      end
      if (clr_ovf) begin m_ovf = 0; m_cnt = 0; end
      if (d) begin
        m_ovf = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("level", level, q.size());
      check("out_valid", out_valid, q.size() != 0);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_cnt);
      if (q.size() != 0)
        check("head", {out_pc, out_wen, out_wnum, out_wdata}, q[0]);
    end
  end

  task automatic cyc(input logic en, input logic [3:0] wen, input logic [4:0] wn,
                     input logic [31:0] pc, input logic [31:0] wd, input logic rdy, input logic clr);
    trace_en = en; wb_rf_wen = wen; wb_rf_wnum = wn; wb_pc = pc; wb_rf_wdata = wd;
    out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int nxt, sent, guard;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_head", {out_pc, out_wen, out_wnum, out_wdata}, 73'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single record, then one pop.
    cyc(1, 4'hF, 5'd8, 32'hBFC00004, 32'h1234, 0, 0);
    check("single_valid", out_valid, 1'b1);
    check("single_pc", out_pc, 32'hBFC00004);
    check("single_wen", out_wen, 4'hF);
    check("single_wnum", out_wnum, 5'd8);
    check("single_wdata", out_wdata, 32'h1234);
    check("single_level", level, 5'd1);
    cyc(0, 4'h0, 5'd0, 0, 0, 1, 0);
    check("single_pop_valid", out_valid, 1'b0);
    check("single_pop_level", level, 5'd0);

    // Ordering across several pointer wraps, consumer ready every other cycle.
    nxt = 0; sent = 0; guard = 0;
    while (nxt < 40 && guard < 300) begin
      logic rdy, en;
      rdy = guard[0];
      en  = (sent < 40) && (q.size() < DEPTH - 2);
      if (out_valid && rdy) begin
        check("order", out_wdata, nxt);
        nxt++;
      end
      cyc(en, 4'hF, 5'd5, 32'h1000 + sent * 4, sent, rdy, 0);
      if (en) sent++;
      guard++;
    end
    check("order_count", nxt, 40);
    check("order_nodrop", drop_cnt, 0);

    // Overflow: 20 captures into a 16-deep FIFO.
    for (int i = 0; i < 20; i++) cyc(1, 4'h3, 5'd9, 32'h2000 + i * 4, 100 + i, 0, 0);
    check("ovf_level", level, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_cnt", drop_cnt, 4);
    check("ovf_head", out_wdata, 100);
    cyc(0, 4'h0, 5'd0, 0, 0, 0, 1);
    check("clr_flag", overflow, 1'b0);
    check("clr_cnt", drop_cnt, 0);
    check("clr_level", level, 5'd16);

    // Full with simultaneous push and pop.
    cyc(1, 4'hF, 5'd3, 32'h3000, 32'hAAAA, 1, 0);
    check("fullpp_level", level, 5'd16);
    check("fullpp_cnt", drop_cnt, 0);
    check("fullpp_head", out_wdata, 101);
    for (int i = 0; i < 15; i++) cyc(0, 4'h0, 5'd0, 0, 0, 1, 0);
    check("fullpp_tail", out_wdata, 32'hAAAA);
    check("fullpp_tail_lvl", level, 5'd1);

    // Filters.
    cyc(1, 4'h0, 5'd4, 32'h4000, 32'h55, 0, 0);
    check("filt_wen0", level, 5'd1);
    cyc(0, 4'hF, 5'd4, 32'h4004, 32'h56, 0, 0);
    check("filt_en0", level, 5'd1);
    cyc(1, 4'hF, 5'd0, 32'h4008, 32'h57, 0, 0);
`ifdef WB_TRACE_R0_FILTER_EN
    check("filt_r0", level, 5'd1);
`else
    check("filt_r0", level, 5'd2);
`endif
    check("filt_r0_nodrop", drop_cnt, 0);

    // Saturation, then drop colliding with clr_ovf.
    do_reset();
    for (int i = 0; i < DEPTH + 20; i++) cyc(1, 4'hF, 5'd7, i * 4, i, 0, 0);
    check("sat_cnt", drop_cnt, CMAX);
    check("sat_head", out_wdata, 0);
    cyc(1, 4'hF, 5'd7, 0, 32'hBEEF, 0, 1);
    check("clrdrop_flag", overflow, 1'b1);
    check("clrdrop_cnt", drop_cnt, 1);

    // Asynchronous reset mid-drain at level 5.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 4'hF, 5'd2, i * 4, 200 + i, 0, 0);
    cyc(0, 4'h0, 5'd0, 0, 0, 1, 0);
    check("pre_arst_level", level, 5'd5);
    #2 reset = 1'b1;
    #1;
    check("arst_level", level, 5'd0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_ovf", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      cyc($urandom_range(0, 7) != 0, w, 5'($urandom), $urandom, $urandom,
          (i < 750) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0),
          $urandom_range(0, 63) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Sits directly downstream of the CPU top and consumes its write-back debug stream: debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum and debug_wb_rf_wdata.
- Captures every register-file write as a trace record in a FIFO.
- Drains records to a trace consumer (UART dumper or golden-trace comparator) over a valid/ready handshake.
- Decouples CPU progress from a slower consumer and counts records lost to overflow.

Parameters:
- DEPTH, 16: number of FIFO entries. Must be a power of 2, ≥2.
- CNT_W, 16: width of the saturating drop counter.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- trace_en, input, 1: capture enable; 0 ignores the write-back stream.
- wb_pc, input, 32: PC of the retiring write (debug_wb_pc).
- wb_rf_wen, input, 4: byte write enables (debug_wb_rf_wen).
- wb_rf_wnum, input, 5: destination register (debug_wb_rf_wnum).
- wb_rf_wdata, input, 32: write data (debug_wb_rf_wdata).
- out_valid, output, 1: head record available.
- out_ready, input, 1: consumer accepts head record.
- out_pc, output, 32: head record PC.
- out_wen, output, 4: head record byte enables.
- out_wnum, output, 5: head record register number.
- out_wdata, output, 32: head record data.
- level, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; set when any record is dropped.
- drop_cnt, output, CNT_W: number of dropped records, saturating.
- clr_ovf, input, 1: synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (async, active-high): rd_ptr=0, wr_ptr=0, level=0, out_valid=0, overflow=0, drop_cnt=0. out_pc, out_wen, out_wnum and out_wdata are 0. Storage contents are don't-care.
- Capture condition: cap = trace_en && (wb_rf_wen != 4'b0000), sampled every rising edge. One record per cycle at most.
- Record is {wb_pc, wb_rf_wen, wb_rf_wnum, wb_rf_wdata}, 73 bits, stored unmodified.
- Pop condition: pop = out_valid && out_ready.
- Push condition: push = cap && (level < DEPTH || pop).
  - When full, a simultaneous pop frees the slot in the same cycle and the push is accepted.
- Drop condition: drop = cap && !push.
  - overflow <= 1.
  - drop_cnt <= drop_cnt + 1, saturating at all-ones.
- clr_ovf: overflow <= 0 and drop_cnt <= 0.
  - If clr_ovf and drop occur in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Latency: no bypass. A record pushed at edge N appears with out_valid=1 after edge N, even if the FIFO was empty.
- Head outputs are combinational reads of mem[rd_ptr] and hold stable while out_valid && !out_ready.
  - When level=0, out_valid=0 and head outputs are don't-care.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- trace_en deassertion affects capture only; draining continues.
- Reset mid-operation discards all buffered records. No partial record is ever presented.

Optional Feature:
- Macro: WB_TRACE_R0_FILTER_EN.
- Defined: cap additionally requires wb_rf_wnum != 5'd0. Writes to $0 are neither stored nor counted as drops.
- Undefined: $0 writes are captured like any other write.

Decomposition:
- Shared package wb_trace_pkg holds:
  - TRACE_REC_W = 73.
  - Field offsets: PC at [72:41], WEN at [40:37], WNUM at [36:32], WDATA at [31:0].
  - A packed struct trace_rec_t.
- One sub-module, trace_fifo_mem: DEPTH x TRACE_REC_W register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, level, handshake and overflow logic live in wb_trace_buffer.

Test Plan:
- Single record: trace_en=1, push pc=0xBFC00004, wen=F, wnum=8, wdata=0x1234 with out_ready=0 → next cycle out_valid=1, head fields match, level=1. Then out_ready=1 for one cycle → out_valid=0, level=0.
- Ordering and wrap: DEPTH=16, push 40 records with wdata=i while out_ready toggles 1/0 each cycle → consumer receives 0..39 in order, no drops, pointers wrap at least twice.
- Overflow: out_ready=0, 20 consecutive captures → level=16, overflow=1, drop_cnt=4, head wdata is the first record. clr_ovf pulse → overflow=0, drop_cnt=0, level still 16.
- Full with simultaneous push/pop: level=16, cap=1 and out_ready=1 in the same cycle → level stays 16, drop_cnt unchanged, new record at tail.
- Filters: wen=0 or trace_en=0 → no push, level unchanged. With WB_TRACE_R0_FILTER_EN, wnum=0 and wen=F → no push and no drop; without the macro, the record is pushed.
- Async reset: assert reset mid-drain with level=5 → level=0, out_valid=0 and overflow=0 immediately, without waiting for a clock edge.
